// File: rtl/drum_pkg.sv
// drum_pkg: voice ids, sequencer state encoding and step geometry shared by the drum sequencer.
package drum_pkg;

    localparam logic [1:0] KICK  = 2'd0;
    localparam logic [1:0] SNARE = 2'd1;
    localparam logic [1:0] HAT   = 2'd2;
    localparam logic [1:0] CLAP  = 2'd3;

    localparam int STEPS  = 16;
    localparam int STEP_W = $clog2(STEPS);

    typedef enum logic [1:0] {
        STOP = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2
    } state_e;

    // Lowest-numbered set voice wins; only meaningful when h != 0.
    function automatic logic [1:0] first_voice(input logic [3:0] h);
        return h[KICK] ? KICK : h[SNARE] ? SNARE : h[HAT] ? HAT : CLAP;
    endfunction

endpackage

// File: rtl/step_timer.sv
// step_timer: loadable down-counter that parks at zero and flags it.
module step_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/drum_sequencer.sv
// drum_sequencer: 16-step, 4-voice pattern sequencer driving the sample player's go/sel/en.
module drum_sequencer
    import drum_pkg::*;
#(
    parameter int TICKS_PER_STEP = 6250000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              play,
    input  logic [1:0]        tempo,
    input  logic              edit_wr,
    input  logic [STEP_W-1:0] edit_step,
    input  logic [1:0]        edit_voice,
    input  logic              edit_val,
    output logic              go,
    output logic [2:0]        sel,
    output logic              en,
    output logic [STEP_W-1:0] step,
    output logic [3:0]        step_hits
);

    localparam int TW = $clog2(TICKS_PER_STEP + 1);

    if ((TICKS_PER_STEP >> 3) < 2) begin : g_bad_ticks
        $error("drum_sequencer: TICKS_PER_STEP>>3 must be >= 2");
    end

    state_e                  state_q, state_d;
    logic [STEPS-1:0][3:0]   pattern_q, pattern_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic [3:0]              hits_q, hits_d;
    logic [2:0]              sel_q, sel_d;
    logic                    go_q, go_d, en_q, en_d;
    logic [TW-1:0]           load_val;
    logic                    tick_done;

    // FIRE costs one cycle, so the timer covers the remaining P-1 cycles.
    assign load_val = TW'(TICKS_PER_STEP >> tempo) - TW'(2);

    step_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (state_q == FIRE),
        .load_val_i (load_val),
        .dec_i      (state_q == WAIT),
        .done_o     (tick_done)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        unique case (state_q)
            STOP: begin
                state_d = play ? FIRE : STOP;
                step_d  = '0;
            end
            FIRE: state_d = WAIT;
            WAIT: begin
                state_d = tick_done ? FIRE : WAIT;
                step_d  = tick_done ? step_q + STEP_W'(1) : step_q;
            end
            default: state_d = STOP;
        endcase
        if (!play) begin
            state_d = STOP;
            step_d  = '0;
        end
    end

    // go/sel read the pre-edit pattern so a same-edge write never alters a trigger.
    always_comb begin
        pattern_d = pattern_q;
        if (edit_wr) pattern_d[edit_step][edit_voice] = edit_val;
        hits_d = pattern_d[step_d];
        go_d   = (state_d == FIRE) && (pattern_q[step_d] != 4'd0);
        sel_d  = go_d ? {1'b0, first_voice(pattern_q[step_d])} : sel_q;
        en_d   = (state_d != STOP);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= STOP;
            pattern_q <= '0;
            step_q    <= '0;
            hits_q    <= '0;
            sel_q     <= '0;
            go_q      <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            step_q    <= step_d;
            hits_q    <= hits_d;
            sel_q     <= sel_d;
            go_q      <= go_d;
            en_q      <= en_d;
        end
    end

    assign go        = go_q;
    assign sel       = sel_q;
    assign en        = en_q;
    assign step      = step_q;
    assign step_hits = hits_q;

endmodule

// File: tb/tb_drum_sequencer.sv
// tb_drum_sequencer: directed checks of the drum sequencer with TICKS_PER_STEP=16.
module tb_drum_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       play = 1'b0;
    logic [1:0] tempo = 2'd0;
    logic       edit_wr = 1'b0;
    logic [3:0] edit_step = 4'd0;
    logic [1:0] edit_voice = 2'd0;
    logic       edit_val = 1'b0;
    logic       go;
    logic [2:0] sel;
    logic       en;
    logic [3:0] step;
    logic [3:0] step_hits;

    int checks = 0;
    int failures = 0;
    int n;

    drum_sequencer #(.TICKS_PER_STEP(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .play       (play),
        .tempo      (tempo),
        .edit_wr    (edit_wr),
        .edit_step  (edit_step),
        .edit_voice (edit_voice),
        .edit_val   (edit_val),
        .go         (go),
        .sel        (sel),
        .en         (en),
        .step       (step),
        .step_hits  (step_hits)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] s, input logic [1:0] v, input logic val);
        edit_wr = 1'b1; edit_step = s; edit_voice = v; edit_val = val;
        cyc();
        edit_wr = 1'b0;
    endtask

    // Cycles until the next go pulse; checks en stays high on the way; bounded.
    task automatic wait_go(output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
            chk("en_while_playing", en, 1'b1);
        end while (!go && cnt < 200);
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        chk("rst_go", go, 0); chk("rst_sel", sel, 0); chk("rst_en", en, 0);
        chk("rst_step", step, 0); chk("rst_hits", step_hits, 0);
        resetn = 1'b1;
        wr(4'd0, 2'd1, 1'b1);
        wr(4'd2, 2'd2, 1'b1);
        tempo = 2'd3; play = 1'b1;
        cyc();
        chk("pre_fire_go", go, 1); chk("pre_fire_sel", sel, 1);
        cyc();
        chk("pre_wait_hits", step_hits, 4'b0010);
        // Reset mid-step with play and a write pending: reset wins
        resetn = 1'b0; edit_wr = 1'b1; edit_step = 4'd5; edit_voice = 2'd0; edit_val = 1'b1;
        cyc();
        chk("rst2_go", go, 0); chk("rst2_sel", sel, 0); chk("rst2_en", en, 0);
        chk("rst2_step", step, 0); chk("rst2_hits", step_hits, 0);
        resetn = 1'b1; edit_wr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cyc();
            chk("cleared_hits", step_hits, 0);
            chk("cleared_go", go, 0);
        end
        play = 1'b0;
        cyc();
        // Kick every 4 steps at P=16
        wr(4'd0, 2'd0, 1'b1); wr(4'd4, 2'd0, 1'b1); wr(4'd8, 2'd0, 1'b1); wr(4'd12, 2'd0, 1'b1);
        tempo = 2'd0; play = 1'b1;
        cyc();
        chk("kick0_go", go, 1); chk("kick0_sel", sel, 0); chk("kick0_step", step, 0); chk("kick0_en", en, 1);
        cyc();
        chk("kick0_go_one_cycle", go, 0);
        for (int k = 1; k <= 4; k++) begin
            wait_go(n);
            chk("kick_interval", n, (k == 1) ? 63 : 64);
            chk("kick_sel", sel, 0);
            chk("kick_step", step, (4 * k) % 16);
        end
        // Step 3 snare+hat+clap at P=4
        play = 1'b0;
        cyc();
        wr(4'd3, 2'd1, 1'b1); wr(4'd3, 2'd2, 1'b1); wr(4'd3, 2'd3, 1'b1);
        tempo = 2'd2; play = 1'b1;
        cyc();
        chk("t2_fire0_go", go, 1); chk("t2_fire0_step", step, 0);
        wait_go(n);
        chk("t2_step3_delay", n, 12); chk("t2_step3_sel", sel, 1); chk("t2_step3_step", step, 3);
        wait_go(n);
        chk("t2_step4_delay", n, 4); chk("t2_step4_sel", sel, 0); chk("t2_step4_step", step, 4);
        // Drop play during FIRE
        play = 1'b0;
        chk("stop_fire_go", go, 1);
        cyc();
        chk("stop_go", go, 0); chk("stop_step", step, 0); chk("stop_en", en, 0);
        chk("stop_hits", step_hits, 4'b0001);
        play = 1'b1;
        cyc();
        chk("restart_go", go, 1); chk("restart_step", step, 0); chk("restart_en", en, 1);
        // Edit current (empty) step during its FIRE
        repeat (4) cyc();
        chk("edit_fire_step", step, 1); chk("edit_fire_go", go, 0); chk("edit_sel_held", sel, 0);
        edit_wr = 1'b1; edit_step = 4'd1; edit_voice = 2'd3; edit_val = 1'b1;
        cyc();
        edit_wr = 1'b0;
        chk("edit_hits", step_hits, 4'b1000); chk("edit_go_after", go, 0); chk("edit_step_after", step, 1);
        repeat (63) cyc();
        chk("edit_loop_step", step, 1); chk("edit_loop_go", go, 1); chk("edit_loop_sel", sel, 3);
        // Tempo change mid-WAIT
        play = 1'b0;
        cyc();
        tempo = 2'd0; play = 1'b1;
        cyc();
        chk("tc_fire0_step", step, 0); chk("tc_fire0_go", go, 1);
        repeat (5) cyc();
        tempo = 2'd3;
        repeat (10) cyc();
        chk("tc_step0_held", step, 0);
        cyc();
        chk("tc_step1", step, 1); chk("tc_step1_go", go, 1); chk("tc_step1_sel", sel, 3);
        cyc();
        chk("tc_step1_wait", step, 1);
        cyc();
        chk("tc_step2", step, 2); chk("tc_step2_go", go, 0);
        repeat (2) cyc();
        chk("tc_step3", step, 3); chk("tc_step3_go", go, 1); chk("tc_step3_sel", sel, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
